// File: rtl/encoder_pkg.sv
// Shared types for the rotary-encoder value controller: event codes and press FSM states.
package encoder_pkg;

   typedef enum logic [1:0] {
      EVT_CW    = 2'd0,
      EVT_CCW   = 2'd1,
      EVT_SHORT = 2'd2,
      EVT_LONG  = 2'd3
   } evt_code_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } press_state_t;

   // Event code for a detent in the given direction.
   function automatic logic [1:0] rot_code(input logic cw);
      return cw ? 2'(EVT_CW) : 2'(EVT_CCW);
   endfunction

endpackage

// File: rtl/encoder_press_fsm.sv
// Push-switch press classifier: measures press duration and emits one-cycle
// short/long strobes (registered, one cycle after the release or terminal count).
module encoder_press_fsm
   import encoder_pkg::*;
#(
   parameter int unsigned LONG_PRESS_CYCLES = 50_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pressed,
   output logic short_stb,
   output logic long_stb
);

   localparam int unsigned      CNT_W      = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [1:0]       ST_IDLE    = 2'(IDLE);
   localparam logic [1:0]       ST_PRESSED = 2'(PRESSED);
   localparam logic [1:0]       ST_HELD    = 2'(HELD);

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             short_nxt, long_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         short_stb <= 1'b0;
         long_stb  <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         short_stb <= short_nxt;
         long_stb  <= long_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      short_nxt = 1'b0;
      long_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pressed) begin
               cnt_nxt   = '0;
               state_nxt = ST_PRESSED;
            end
         end
         ST_PRESSED: begin
            if (!pressed) begin
               short_nxt = 1'b1;
               state_nxt = ST_IDLE;
            end else if (cnt == CNT_LAST) begin
               long_nxt  = 1'b1;
               state_nxt = ST_HELD;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_HELD: begin
            // Release after a long press is silent.
            if (!pressed) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/encoder_value_ctrl.sv
// Rotary-encoder value controller: saturating parameter value, press classification
// and a one-deep CPU event channel. Define ENC_ACCEL_EN to enable detent acceleration.
module encoder_value_ctrl
   import encoder_pkg::*;
#(
   parameter int unsigned VALUE_W           = 8,
   parameter int unsigned VALUE_MIN         = 0,
   parameter int unsigned VALUE_MAX         = 255,
   parameter int unsigned VALUE_RESET       = 128,
   parameter int unsigned STEP_SLOW         = 1,
   parameter int unsigned STEP_FAST         = 4,
   parameter int unsigned ACCEL_WINDOW      = 1_000_000,
   parameter int unsigned LONG_PRESS_CYCLES = 50_000_000,
   parameter bit          SW_ACTIVE_LOW     = 1'b1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clockwise,
   input  logic               click,
   input  logic               switch,
   input  logic               load,
   input  logic [VALUE_W-1:0] load_value,
   output logic [VALUE_W-1:0] value,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [1:0]         evt_code,
   output logic               evt_overrun,
   input  logic               overrun_clr
);

   localparam int unsigned        EW       = VALUE_W + 1;
   localparam logic [EW-1:0]      MIN_E    = EW'(VALUE_MIN);
   localparam logic [EW-1:0]      MAX_E    = EW'(VALUE_MAX);
   localparam logic [EW-1:0]      SLOW_E   = EW'(STEP_SLOW);
   localparam logic [EW-1:0]      FAST_E   = EW'(STEP_FAST);
   localparam logic [VALUE_W-1:0] RESET_V  = VALUE_W'(VALUE_RESET);

   logic               click_dly;
   logic               detent_c;
   logic               fast_c;
   logic               pressed_c;
   logic               short_stb, long_stb;
   logic [EW-1:0]      step_c, val_e, ld_e, up_e;
   logic [VALUE_W-1:0] value_nxt;
   logic               evt_valid_nxt, overrun_nxt;
   logic [1:0]         evt_code_nxt;
   logic               rot_new_c, press_new_c, drop_c;

   assign detent_c  = click & ~click_dly;
   assign pressed_c = switch ^ SW_ACTIVE_LOW;

`ifdef ENC_ACCEL_EN
   localparam int unsigned      GAP_W   = $clog2(ACCEL_WINDOW + 1);
   localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(ACCEL_WINDOW);

   logic [GAP_W-1:0] gap, gap_nxt;
   logic             last_cw;

   // Fast step only for a same-direction detent inside the window.
   always_comb begin
      fast_c  = (gap < GAP_MAX) && (clockwise == last_cw);
      gap_nxt = gap;
      if (load)                 gap_nxt = GAP_MAX;
      else if (detent_c)        gap_nxt = '0;
      else if (gap != GAP_MAX)  gap_nxt = gap + GAP_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gap     <= GAP_MAX;
         last_cw <= 1'b0;
      end else begin
         gap <= gap_nxt;
         if (detent_c && !load) last_cw <= clockwise;
      end
   end
`else
   assign fast_c = 1'b0;
`endif

   encoder_press_fsm #(
      .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
   ) u_press (
      .clk       (clk),
      .reset_n   (reset_n),
      .pressed   (pressed_c),
      .short_stb (short_stb),
      .long_stb  (long_stb)
   );

   // Value update; one spare bit keeps the saturation compares overflow-free.
   always_comb begin
      step_c    = fast_c ? FAST_E : SLOW_E;
      val_e     = {1'b0, value};
      ld_e      = {1'b0, load_value};
      up_e      = val_e + step_c;
      value_nxt = value;
      if (load) begin
         if (ld_e > MAX_E)                 value_nxt = VALUE_W'(MAX_E);
         else if ((ld_e + EW'(1)) <= MIN_E) value_nxt = VALUE_W'(MIN_E);
         else                              value_nxt = load_value;
      end else if (detent_c) begin
         if (clockwise) value_nxt = (up_e > MAX_E) ? VALUE_W'(MAX_E) : VALUE_W'(up_e);
         else           value_nxt = (val_e >= (MIN_E + step_c)) ? VALUE_W'(val_e - step_c)
                                                                 : VALUE_W'(MIN_E);
      end
   end

   // One-deep event slot; rotation wins over a coincident press.
   always_comb begin
      rot_new_c     = detent_c & ~load;
      press_new_c   = short_stb | long_stb;
      evt_valid_nxt = evt_valid;
      evt_code_nxt  = evt_code;
      overrun_nxt   = evt_overrun;
      drop_c        = 1'b0;
      if (rot_new_c || press_new_c) begin
         if (!evt_valid || evt_ready) begin
            evt_valid_nxt = 1'b1;
            if (rot_new_c)     evt_code_nxt = rot_code(clockwise);
            else if (long_stb) evt_code_nxt = 2'(EVT_LONG);
            else               evt_code_nxt = 2'(EVT_SHORT);
         end else begin
            drop_c = 1'b1;
         end
         if (rot_new_c && press_new_c) drop_c = 1'b1;
      end else if (evt_valid && evt_ready) begin
         evt_valid_nxt = 1'b0;
      end
      if (drop_c)           overrun_nxt = 1'b1;
      else if (overrun_clr) overrun_nxt = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         click_dly   <= 1'b1;
         value       <= RESET_V;
         evt_valid   <= 1'b0;
         evt_code    <= 2'(EVT_CW);
         evt_overrun <= 1'b0;
      end else begin
         click_dly   <= click;
         value       <= value_nxt;
         evt_valid   <= evt_valid_nxt;
         evt_code    <= evt_code_nxt;
         evt_overrun <= overrun_nxt;
      end
   end

endmodule
